// File: rtl/lif_spike_counter_if.sv
// Bus between the neuron and its driver. The driver supplies the step
// strobe and the current. The neuron returns its spike, its membrane
// potential and the windowed spike count.
//   master : drives step/current, observes spike/state/counter/window_done
//   slave  : the neuron side
interface lif_spike_counter_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 step;
  logic [WIDTH-1:0]     current;
  logic                 spike;
  logic [WIDTH-1:0]     state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 window_done;

  modport master (
    output step, current,
    input  spike, state, counter, window_done
  );

  modport slave (
    input  step, current,
    output spike, state, counter, window_done
  );
endinterface

// File: rtl/lif_spike_counter.sv
// Leaky integrate-and-fire neuron with a windowed spike counter.
// On each step strobe the neuron decays its membrane, adds the input
// current, fires at threshold and counts spikes over WINDOW steps. At
// the end of each window it latches the count for the seg7 decoder.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous reset, active-high, highest priority
//   bus  : slave side of the bus (step, current in; spike, state,
//          counter, window_done out)
module lif_spike_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned THRESHOLD  = 200,
  parameter int unsigned BETA_SHIFT = 1,
  parameter int unsigned RESET_ZERO = 0,
  parameter int unsigned CNT_WIDTH  = 4,
  parameter int unsigned WINDOW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  lif_spike_counter_if.slave bus
);

  localparam int unsigned IDX_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned LAST_M1 = (WINDOW > 1) ? WINDOW - 2 : 0;
  localparam logic [WIDTH+1:0] THR_X = (WIDTH+2)'(THRESHOLD);

  typedef enum logic {S_COUNT, S_LAST} fsm_t;
  localparam fsm_t S_RST = (WINDOW == 1) ? S_LAST : S_COUNT;

  fsm_t                 r_fsm;
  fsm_t                 w_fsm_nxt;
  logic                 w_last;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_WIDTH-1:0] r_scnt;
  logic [CNT_WIDTH-1:0] r_counter;
  logic                 r_window_done;
  logic [WIDTH-1:0]     r_state;
  logic                 r_spike;

  logic                 w_fire;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH+1:0]     w_pre;
  logic [WIDTH-1:0]     w_state_nxt;
  logic [CNT_WIDTH-1:0] w_scnt_sat;

  // Membrane update: fire on the pre-update state, decay, integrate, reset.
  always_comb begin
    w_fire = (r_state >= WIDTH'(THRESHOLD));
    w_sum  = (WIDTH+1)'(r_state >> BETA_SHIFT) + (WIDTH+1)'(bus.current);
    if (RESET_ZERO != 0) begin
      w_pre = w_fire ? '0 : {1'b0, w_sum};
    end else begin
      w_pre = {1'b0, w_sum} - (w_fire ? THR_X : '0);
    end
    // Bit WIDTH+1 is the sign of the two's-complement result.
    if (w_pre[WIDTH+1]) begin
      w_state_nxt = '0;
    end else if (w_pre[WIDTH]) begin
      w_state_nxt = '1;
    end else begin
      w_state_nxt = w_pre[WIDTH-1:0];
    end
  end

  // Spike count including this step's fire, saturating at the top.
  always_comb begin
    w_scnt_sat = (r_scnt == '1) ? '1 : r_scnt + CNT_WIDTH'(w_fire);
  end

  // Window FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_RST;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Window FSM next state. LAST is the final step of a window.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_last    = (r_fsm == S_LAST);
    if (bus.step) begin
      case (r_fsm)
        S_COUNT: if (r_idx == IDX_W'(LAST_M1)) w_fsm_nxt = S_LAST;
        S_LAST:  w_fsm_nxt = S_RST;
        default: w_fsm_nxt = S_RST;
      endcase
    end
  end

  // Neuron and counter registers; everything advances only on step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= '0;
      r_spike       <= 1'b0;
      r_counter     <= '0;
      r_window_done <= 1'b0;
      r_scnt        <= '0;
      r_idx         <= '0;
    end else begin
      r_window_done <= 1'b0;
      if (bus.step) begin
        r_spike <= w_fire;
        r_state <= w_state_nxt;
        if (w_last) begin
          r_counter     <= w_scnt_sat;
          r_scnt        <= '0;
          r_idx         <= '0;
          r_window_done <= 1'b1;
        end else begin
          r_scnt <= w_scnt_sat;
          r_idx  <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.spike       = r_spike;
  assign bus.state       = r_state;
  assign bus.counter     = r_counter;
  assign bus.window_done = r_window_done;

endmodule

// File: tb/tb_lif_spike_counter.sv
// Bench for lif_spike_counter. It runs three instances side by side:
// the defaults (a), zero reset (z) and zero reset with a 40-step window (w).
module tb_lif_spike_counter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  lif_spike_counter_if #(.WIDTH(8), .CNT_WIDTH(4)) ifa ();
  lif_spike_counter_if #(.WIDTH(8), .CNT_WIDTH(4)) ifz ();
  lif_spike_counter_if #(.WIDTH(8), .CNT_WIDTH(4)) ifw ();

  lif_spike_counter dut_a (.clk(clk), .rst(rst), .bus(ifa));
  lif_spike_counter #(.RESET_ZERO(1)) dut_z (.clk(clk), .rst(rst), .bus(ifz));
  lif_spike_counter #(.RESET_ZERO(1), .WINDOW(40)) dut_w (.clk(clk), .rst(rst), .bus(ifw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int sp;
    int cnt;
    int wd;
  } exp_t;

  exp_t exp_q[$];

  int m_st[3], m_sp[3], m_cnt[3], m_scnt[3], m_idx[3], m_wd[3];
  int p_rz[3]  = '{0, 1, 1};
  int p_win[3] = '{16, 16, 40};

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference neuron: integer arithmetic, clamp applied to the final value.
  task automatic model(input int k, input bit s, input bit r, input int cur);
    int fire, nxt, c;
    if (r) begin
      m_st[k] = 0; m_sp[k] = 0; m_cnt[k] = 0; m_scnt[k] = 0; m_idx[k] = 0; m_wd[k] = 0;
    end else if (s) begin
      fire = (m_st[k] >= 200) ? 1 : 0;
      nxt  = (m_st[k] / 2) + cur;
      if (p_rz[k] != 0) nxt = fire ? 0 : nxt;
      else              nxt = nxt - (fire ? 200 : 0);
      if (nxt < 0)   nxt = 0;
      if (nxt > 255) nxt = 255;
      m_st[k] = nxt;
      m_sp[k] = fire;
      c = m_scnt[k] + fire;
      if (c > 15) c = 15;
      if (m_idx[k] == p_win[k] - 1) begin
        m_cnt[k] = c; m_scnt[k] = 0; m_idx[k] = 0; m_wd[k] = 1;
      end else begin
        m_scnt[k] = c; m_idx[k]++; m_wd[k] = 0;
      end
    end else begin
      m_wd[k] = 0;
    end
  endtask

  // One clock: drive, push expectations, then pop and compare after the edge.
  task automatic cycle(input bit s, input bit r, input int cur);
    exp_t e;
    @(negedge clk);
    rst = r;
    ifa.step = s; ifz.step = s; ifw.step = s;
    ifa.current = 8'(cur);
    model(0, s, r, cur);
    model(1, s, r, 255);
    model(2, s, r, 255);
    for (int k = 0; k < 3; k++) begin
      e.st = m_st[k]; e.sp = m_sp[k]; e.cnt = m_cnt[k]; e.wd = m_wd[k];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("a.state", int'(ifa.state), e.st);
    check("a.spike", int'(ifa.spike), e.sp);
    check("a.counter", int'(ifa.counter), e.cnt);
    check("a.window_done", int'(ifa.window_done), e.wd);
    e = exp_q.pop_front();
    check("z.state", int'(ifz.state), e.st);
    check("z.spike", int'(ifz.spike), e.sp);
    check("z.counter", int'(ifz.counter), e.cnt);
    check("z.window_done", int'(ifz.window_done), e.wd);
    e = exp_q.pop_front();
    check("w.state", int'(ifw.state), e.st);
    check("w.spike", int'(ifw.spike), e.sp);
    check("w.counter", int'(ifw.counter), e.cnt);
    check("w.window_done", int'(ifw.window_done), e.wd);
  endtask

  int seq2[9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
  int seq3[7] = '{101, 151, 176, 189, 195, 198, 200};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ifa.step = 1'b0; ifz.step = 1'b0; ifw.step = 1'b0;
    ifa.current = '0; ifz.current = 8'd255; ifw.current = 8'd255;
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // Constant current 100: converges below threshold, never fires.
    for (int i = 1; i <= 80; i++) begin
      cycle(1, 0, 100);
      if (i <= 9) check("t2.state", int'(ifa.state), seq2[i-1]);
      check("t2.spike", int'(ifa.spike), 0);
      if (i == 16) begin
        check("t4.z_wd", int'(ifz.window_done), 1);
        check("t4.z_counter", int'(ifz.counter), 8);
        check("t2.a_counter", int'(ifa.counter), 0);
      end
      if (i == 40 || i == 80) check("t5.w_counter", int'(ifw.counter), 15);
      if (i == 41) check("t5.w_wd_clear", int'(ifw.window_done), 0);
    end

    // Mid-run reset for two cycles.
    cycle(1, 0, 150);
    cycle(1, 1, 150);
    cycle(0, 1, 150);
    check("t1.state", int'(ifa.state), 0);
    check("t1.spike", int'(ifa.spike), 0);
    check("t1.counter", int'(ifz.counter), 0);
    check("t1.wd", int'(ifa.window_done), 0);

    // Constant current 101: fires on step 8 with subtract reset.
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 101);
      if (i <= 7) check("t3.state", int'(ifa.state), seq3[i-1]);
      if (i == 8) begin
        check("t3.s8_spike", int'(ifa.spike), 1);
        check("t3.s8_state", int'(ifa.state), 1);
      end
      if (i == 9) begin
        check("t3.s9_spike", int'(ifa.spike), 0);
        check("t3.s9_state", int'(ifa.state), 101);
      end
      if (i == 15) check("t1.no_early_wd", int'(ifz.window_done), 0);
      if (i == 16) check("t1.full_window_wd", int'(ifz.window_done), 1);
    end

    // Random currents and gaps, exercising both clamp directions.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 0, ((i % 50) > 35) ? 0 : int'($urandom_range(0, 255)));
    end

    // Strobed every third cycle, reset coinciding with step 10.
    cycle(0, 1, 0);
    for (int i = 1; i <= 30; i++) begin
      cycle(0, 0, 101);
      cycle(0, 0, 101);
      cycle(1, (i == 10) ? 1'b1 : 1'b0, 101);
      if (i <= 7) check("t6.state", int'(ifa.state), seq3[i-1]);
      if (i == 8) check("t6.s8_state", int'(ifa.state), 1);
      if (i == 10) begin
        check("t6.rst_state", int'(ifa.state), 0);
        check("t6.rst_counter", int'(ifz.counter), 0);
      end
      if (i == 25) check("t6.restart_wd", int'(ifz.window_done), 0);
      if (i == 26) check("t6.window_wd", int'(ifz.window_done), 1);
    end

    if (exp_q.size() != 0) check("scoreboard.drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
